// File: rtl/dlx_pkg.sv
// Shared DLX constants: instruction geometry, default datapath widths and reset PC.
// Used by fetch, decode and the ROM test harness.
package dlx_pkg;

  localparam int          INSTR_BYTES    = 4;
  localparam int          PC_ALIGN_BITS  = 2;
  localparam int          DLX_DATA_WIDTH = 32;
  localparam int          DLX_ADDR_WIDTH = 32;
  localparam logic [31:0] DLX_RESET_PC   = 32'h0;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO between the instruction ROM and decode.
// Entry 0 is the head register and drives the stage outputs directly; flush dominates push/pop.
module fetch_skid_fifo #(
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot1;
  logic             do_pop;
  logic             do_push;

  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != 2'd2) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (do_pop) begin
        // Popping a full FIFO shifts the second entry into the head slot.
        if (count == 2'd2) head <= slot1;
        if (do_push) begin
          if (count == 2'd2) slot1 <= din;
          else               head  <= din;
        end
      end else if (do_push) begin
        if (count == 2'd0) head  <= din;
        else               slot1 <= din;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/dlx_fetch.sv
// DLX instruction-fetch stage: PC tracking, synchronous ROM request issue, redirect squash,
// and a 2-entry skid buffer presenting {instr, pc, npc} to decode.
//
// Handshake: decode consumes the head when if_valid & id_ready are both high at a posedge;
// while if_valid is high and id_ready low, if_* hold steady.
module dlx_fetch
  import dlx_pkg::*;
#(
  parameter int                    DATA_WIDTH = DLX_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DLX_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DLX_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  halt,
  output logic                  rom_rd_ena,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  id_ready,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [ADDR_WIDTH-1:0] if_npc
);

  localparam int                    PKT_W   = DATA_WIDTH + 2 * ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] PC_MASK = ~ADDR_WIDTH'(INSTR_BYTES - 1);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] req_pc_q;
  logic                  req_q;
  logic [ADDR_WIDTH-1:0] issue_pc;
  logic                  issue;
  logic                  pop;
  logic                  push;
  logic [1:0]            fifo_count;
  logic [2:0]            occ;
  logic [PKT_W-1:0]      fifo_din;
  logic [PKT_W-1:0]      fifo_head;

  assign if_valid = (fifo_count != 2'd0);
  assign {if_instr, if_pc, if_npc} = fifo_head;

  always_comb begin
    pop      = if_valid & id_ready;
    occ      = {1'b0, fifo_count} + {2'b00, req_q};
    issue_pc = redirect_valid ? (redirect_pc & PC_MASK) : fetch_pc;
    // Occupancy counts the in-flight word, so buffered + pending never exceeds two.
    issue    = rst_n & (redirect_valid |
                        (!halt & ((occ < 3'd2) | ((occ == 3'd2) & pop))));
    // A response arriving while a redirect is taken belongs to the wrong path.
    push     = req_q & !redirect_valid;
    fifo_din = {rom_data, req_pc_q, req_pc_q + STEP};
  end

  assign rom_rd_ena  = issue;
  assign rom_address = issue_pc >> PC_ALIGN_BITS;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc_q <= '0;
      req_q    <= 1'b0;
    end else begin
      req_q <= issue;
      if (issue) begin
        req_pc_q <= issue_pc;
        fetch_pc <= issue_pc + STEP;
      end
    end
  end

  fetch_skid_fifo #(
    .WIDTH (PKT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (fifo_din),
    .head  (fifo_head),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_dlx_fetch.sv
// Bench for dlx_fetch: directed steps plus a randomized phase, checked against a
// program-order PC model (sequential +4, restart on redirect/reset).
module tb_dlx_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;

  logic        rom_rd_ena, if_valid;
  logic [31:0] rom_address, rom_data, if_instr, if_pc, if_npc;
  logic        rom_rd_ena2, if_valid2;
  logic [31:0] rom_address2, rom_data2, if_instr2, if_pc2, if_npc2;

  int tests = 0;
  int fails = 0;
  int pops  = 0;

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  always @(posedge clk) if (rom_rd_ena)  rom_data  <= rom_word(rom_address);
  always @(posedge clk) if (rom_rd_ena2) rom_data2 <= rom_word(rom_address2);

  dlx_fetch dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .rom_rd_ena(rom_rd_ena), .rom_address(rom_address), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_npc(if_npc)
  );

  dlx_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .rom_rd_ena(rom_rd_ena2), .rom_address(rom_address2), .rom_data(rom_data2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2), .if_npc(if_npc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after posedge, outputs sampled on negedge
  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (if_valid) ok = 1'b1;
      else adv();
    end
  endtask

  // scoreboard: expected program-order PCs of the next instructions decode should see
  logic [31:0] exp_q[$];
  logic        prev_stall, prev_redir;
  logic [31:0] prev_instr, prev_pc, prev_npc;

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      exp_q.delete();
      exp_q.push_back(32'h0);
      prev_stall = 1'b0;
      prev_redir = 1'b0;
    end else begin
      if (prev_stall && !prev_redir) begin
        chk("stall_valid", {31'b0, if_valid}, 32'd1);
        chk("stall_instr", if_instr, prev_instr);
        chk("stall_pc",    if_pc,    prev_pc);
        chk("stall_npc",   if_npc,   prev_npc);
      end
      if (if_valid && id_ready) begin
        e = exp_q.pop_front();
        chk("seq_pc",    if_pc,    e);
        chk("seq_instr", if_instr, rom_word(e >> 2));
        chk("seq_npc",   if_npc,   e + 32'd4);
        pops++;
      end
      if (redirect_valid) begin
        exp_q.delete();
        exp_q.push_back(redirect_pc & ~32'h3);
      end
      if (exp_q.size() == 0) exp_q.push_back(32'h0);
      while (exp_q.size() < 4) exp_q.push_back(exp_q[$] + 32'd4);
      prev_stall = if_valid && !id_ready;
      prev_redir = redirect_valid;
      prev_instr = if_instr;
      prev_pc    = if_pc;
      prev_npc   = if_npc;
    end
  end

  initial begin
    bit ok;
    logic [31:0] wpc;
    rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    repeat (3) adv();
    smp();
    chk("rst_rd_ena", {31'b0, rom_rd_ena}, 32'd0);
    chk("rst_valid",  {31'b0, if_valid},   32'd0);
    chk("rst_instr",  if_instr, 32'h0);
    chk("rst_pc",     if_pc,    32'h0);
    chk("rst_npc",    if_npc,   32'h0);

    // reset release, id_ready=1: one instruction per cycle from cycle 2
    adv(); rst_n = 1'b1;
    smp();
    chk("c0_rd_ena", {31'b0, rom_rd_ena}, 32'd1);
    chk("c0_addr",   rom_address,  32'h0);
    chk("c0_addr_w", rom_address2, 32'h3FFF_FFFE);
    chk("c0_valid",  {31'b0, if_valid}, 32'd0);
    adv(); smp();
    chk("c1_addr",  rom_address, 32'h1);
    chk("c1_valid", {31'b0, if_valid}, 32'd0);
    for (int c = 2; c < 8; c++) begin
      adv(); smp();
      chk("str_addr",  rom_address, 32'(c));
      chk("str_valid", {31'b0, if_valid}, 32'd1);
      chk("str_pc",    if_pc,    32'(4 * (c - 2)));
      chk("str_instr", if_instr, 32'hA000_0000 + 32'(c - 2));
      chk("str_npc",   if_npc,   32'(4 * (c - 1)));
      wpc = 32'hFFFF_FFF8 + 32'(4 * (c - 2));
      chk("wrap_valid", {31'b0, if_valid2}, 32'd1);
      chk("wrap_pc",    if_pc2,    wpc);
      chk("wrap_npc",   if_npc2,   wpc + 32'd4);
      chk("wrap_instr", if_instr2, rom_word(wpc >> 2));
    end

    // decode stall for 5 cycles
    adv(); id_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("hold_rd_ena", {31'b0, rom_rd_ena}, 32'd0);
      chk("hold_pc",     if_pc, 32'h18);
      adv();
    end
    id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("resume_valid", {31'b0, if_valid}, 32'd1);
      chk("resume_pc",    if_pc, 32'h18 + 32'(4 * k));
      adv();
    end

    // redirect to 0x100 while the FIFO is full
    id_ready = 1'b0; adv(); adv();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    smp();
    chk("rd_full_valid", {31'b0, if_valid}, 32'd1);
    chk("rd_rd_ena",     {31'b0, rom_rd_ena}, 32'd1);
    chk("rd_addr",       rom_address, 32'h40);
    adv(); redirect_valid = 1'b0; id_ready = 1'b1;
    smp(); chk("rd_bubble", {31'b0, if_valid}, 32'd0);
    adv(); smp();
    chk("rd_valid", {31'b0, if_valid}, 32'd1);
    chk("rd_instr", if_instr, 32'hA000_0040);
    chk("rd_pc",    if_pc,    32'h100);
    chk("rd_npc",   if_npc,   32'h104);

    // misaligned redirect target
    adv(); redirect_valid = 1'b1; redirect_pc = 32'h103;
    smp(); chk("mis_addr", rom_address, 32'h40);
    adv(); redirect_valid = 1'b0;
    smp(); chk("mis_bubble", {31'b0, if_valid}, 32'd0);
    adv(); smp(); chk("mis_pc", if_pc, 32'h100);

    // back-to-back redirects: only the second stream survives
    adv(); redirect_valid = 1'b1; redirect_pc = 32'h40;
    adv(); redirect_pc = 32'h80;
    smp(); chk("b2b_addr", rom_address, 32'h20);
    adv(); redirect_valid = 1'b0;
    smp(); chk("b2b_bubble", {31'b0, if_valid}, 32'd0);
    adv(); smp();
    chk("b2b_pc",    if_pc,    32'h80);
    chk("b2b_instr", if_instr, 32'hA000_0020);

    // halt drains the buffer, then resumes sequentially
    adv(); halt = 1'b1;
    repeat (4) adv();
    smp();
    chk("halt_valid",  {31'b0, if_valid},   32'd0);
    chk("halt_rd_ena", {31'b0, rom_rd_ena}, 32'd0);
    adv(); halt = 1'b0;
    wait_valid(ok);
    chk("halt_resume", {31'b0, ok}, 32'd1);

    // reset mid-stream
    repeat (3) adv();
    rst_n = 1'b0;
    smp(); chk("mrst_rd_ena", {31'b0, rom_rd_ena}, 32'd0);
    adv(); smp();
    chk("mrst_valid", {31'b0, if_valid}, 32'd0);
    chk("mrst_instr", if_instr, 32'h0);
    chk("mrst_pc",    if_pc,    32'h0);
    chk("mrst_npc",   if_npc,   32'h0);
    adv(); rst_n = 1'b1;
    smp(); chk("mrst_addr", rom_address, 32'h0);
    adv();
    wait_valid(ok);
    chk("mrst_refetch", {31'b0, ok}, 32'd1);
    chk("mrst_pc0",     if_pc, 32'h0);

    // randomized traffic
    pops = 0;
    adv();
    for (int i = 0; i < 2000; i++) begin
      id_ready       = ($urandom_range(0, 3) != 0);
      halt           = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 16'hFFFF));
      adv();
    end
    redirect_valid = 1'b0; halt = 1'b0; id_ready = 1'b1;
    repeat (6) adv();
    chk("rand_progress", {31'b0, pops > 500}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
